queen_solution_collector: RTL and testbench
===========================================

# queen_solution_collector

Receive side of the 8-queens solver's output bus. Captures one solution as eight successive one-hot row bytes, checks it independently for legality (one-hot rows, no shared column, no shared diagonal), and counts legal solutions. Keeps the last legal board readable for the host and reports the end of search. Sits directly after the solver datapath/controller pair and is the bench's self-check and the host-facing result port.

## Interface
Parameters:
- `COUNT_W`, default 7: solution counter width; saturates at all-ones (92 fits).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `in_valid`  in  1  the solver drives a row byte this cycle.
- `in_row_data`  in  8  one-hot column of the current row; the first byte is row 0.
- `in_ready`  out  1  the collector accepts a byte this cycle.
- `search_done`  in  1  the solver has finished its search; level, sampled every cycle.
- `solution_valid`  out  1  one-cycle pulse: the captured board is legal.
- `solution_error`  out  1  one-cycle pulse: the captured board is illegal.
- `error_code`  out  2  reason for the error, held until the next report: 00 none, 01 not one-hot, 10 column conflict, 11 diagonal conflict.
- `solution_count`  out  COUNT_W  number of legal boards since reset.
- `truncated`  out  1  sticky: `search_done` arrived during a partial capture.
- `finished`  out  1  high once the search has ended; stays high until reset.
- `read_row`  in  3  row select for the stored board.
- `read_data`  out  8  combinational: the `read_row` byte of the last legal board.

## Operation
- States: IDLE, CAPTURE, CHECK, REPORT, FINISHED. The state encoding and error codes live in the package.
- IDLE:
  - `in_ready`=1.
  - An accepted byte (`in_valid & in_ready`) goes into capture slot 0, sets row index 1 and moves to CAPTURE.
  - `search_done`=1 with no byte this cycle moves to FINISHED. If both arrive in the same cycle, the byte wins.
- CAPTURE:
  - `in_ready`=1.
  - Each accepted byte goes into slot[index] and the index increments.
  - Accepting the byte for slot 7 moves to CHECK with `in_ready`=0.
  - `search_done` in CAPTURE with no byte: discard the partial board, set `truncated`, move to FINISHED.
- CHECK (one cycle):
  - Evaluate all 28 row pairs combinationally.
  - Priority of error reasons: any slot not exactly one-hot gives 01; else any pair sharing a column gives 10; else any pair on the same diagonal (row i byte shifted by j-i, either direction, overlaps row j byte) gives 11.
  - Latch `error_code` and move to REPORT.
- REPORT (one cycle):
  - If `error_code`=00: pulse `solution_valid`, increment `solution_count` (saturating), copy the capture slots into the stored board.
  - Otherwise: pulse `solution_error` and leave the stored board unchanged.
  - Move to IDLE.
- FINISHED: `finished`=1, `in_ready`=0, bytes ignored. Leave only via reset.
- Reset values: state IDLE, `in_ready`=1 on the first cycle after reset, pulses 0, `error_code` 00, count 0, `truncated` 0, `finished` 0, stored board all zero.
- A reset during any state abandons the capture immediately. No report is issued.

## Timing
- Byte accept rate is one per cycle while `in_ready`=1. Back-to-back bytes are legal, and so are bubbles (`in_valid`=0).
- Latency from the 8th byte accepted (edge N) to the report: CHECK during cycle N+1, REPORT pulse during cycle N+2. `solution_count` and the stored board update at edge N+2→N+3.
- `in_ready` is low for exactly 2 cycles (CHECK, REPORT) per board. The next board's row 0 can be accepted in cycle N+3.
- `read_data` reflects the stored board with no cycle delay. An update becomes visible the cycle after the REPORT pulse.
- `search_done` is sampled only in IDLE and CAPTURE. During CHECK or REPORT it takes effect once the collector returns to IDLE.

## Structure
- Package `queen_collector_pkg`: `N_QUEENS`=8, the state enum, the error-code constants, and a `row_t` 8-bit typedef.
- One sub-module, `queen_pair_conflict`:
  - Inputs: two one-hot bytes and a 3-bit row distance.
  - Outputs: `col_hit`, `diag_hit`.
  - Instantiated 28 times via generate.
- The one-hot check is an inline function in the package.

## Test plan
- Legal board rows {01,10,80,20,04,40,02,08} (hex, rows 0..7), with one bubble after row 3 → `solution_valid` pulse 2 cycles after the 8th byte; count 1; `read_row`=2 returns 80.
- Rows 0 and 5 both 01, others legal → `solution_error`, `error_code`=10, count unchanged, stored board unchanged from the previous scenario.
- Diagonal conflict: row0=01, row1=02, rest arbitrary one-hot distinct columns → `error_code`=11.
- Row 4 = 03 (two bits) together with a column conflict → `error_code`=01 (priority).
- All 92 solutions streamed from a reference model, then `search_done` → count 92, `finished`=1, `truncated`=0, `in_ready`=0.
- 3 bytes accepted, then `search_done` → `truncated`=1, `finished`=1, no report pulse. Reset mid-CAPTURE with 5 bytes accepted → all outputs at reset values next cycle, and a following legal board counts as 1.

Source files
------------

// File: rtl/queen_collector_pkg.sv
// Shared types, FSM encoding, error codes and the one-hot helper for the
// 8-queens solution collector.
package queen_collector_pkg;

  localparam int N_QUEENS = 8;
  localparam int N_PAIRS  = N_QUEENS * (N_QUEENS - 1) / 2;

  typedef logic [7:0] row_t;
  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_CAPTURE  = 3'd1;
  localparam state_t S_CHECK    = 3'd2;
  localparam state_t S_REPORT   = 3'd3;
  localparam state_t S_FINISHED = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ONE_HOT = 2'b01;
  localparam logic [1:0] ERR_COLUMN  = 2'b10;
  localparam logic [1:0] ERR_DIAG    = 2'b11;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_one_hot(input row_t r);
    return (r != '0) && ((r & (r - 8'd1)) == '0);
  endfunction

endpackage

// File: rtl/queen_pair_conflict.sv
// Column / diagonal conflict between two one-hot rows a given distance apart.
module queen_pair_conflict
  import queen_collector_pkg::*;
(
  input  row_t       row_a,
  input  row_t       row_b,
  input  logic [2:0] row_dist,
  output logic       col_hit,
  output logic       diag_hit
);

  row_t w_up;
  row_t w_dn;

  assign w_up     = row_a << row_dist;
  assign w_dn     = row_a >> row_dist;
  assign col_hit  = |(row_a & row_b);
  assign diag_hit = |((w_up | w_dn) & row_b);

endmodule

// File: rtl/queen_solution_collector.sv
// Captures eight one-hot row bytes, checks the board for legality, counts legal
// boards and keeps the last legal board readable for the host.
module queen_solution_collector
  import queen_collector_pkg::*;
#(
  parameter int unsigned COUNT_W = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_row_data,
  output logic               in_ready,
  input  logic               search_done,
  output logic               solution_valid,
  output logic               solution_error,
  output logic [1:0]         error_code,
  output logic [COUNT_W-1:0] solution_count,
  output logic               truncated,
  output logic               finished,
  input  logic [2:0]         read_row,
  output logic [7:0]         read_data
);

  state_t             r_state;
  row_t               r_slot  [N_QUEENS];
  row_t               r_board [N_QUEENS];
  logic [2:0]         r_idx;
  logic [1:0]         r_error_code;
  logic [COUNT_W-1:0] r_count;
  logic               r_truncated;

  logic               w_accept;
  logic [N_QUEENS-1:0] w_one_hot;
  logic [N_PAIRS-1:0]  w_col;
  logic [N_PAIRS-1:0]  w_diag;
  logic [1:0]         w_err_code;

  for (genvar gk = 0; gk < N_QUEENS; gk++) begin : g_one_hot
    assign w_one_hot[gk] = is_one_hot(r_slot[gk]);
  end

  // Pairs are numbered row-major over the upper triangle (i < j).
  for (genvar gi = 0; gi < N_QUEENS - 1; gi++) begin : g_row
    for (genvar gj = gi + 1; gj < N_QUEENS; gj++) begin : g_pair
      localparam int PAIR_IDX = gi * (2 * N_QUEENS - 1 - gi) / 2 + gj - gi - 1;
      queen_pair_conflict u_pair (
        .row_a   (r_slot[gi]),
        .row_b   (r_slot[gj]),
        .row_dist(3'(gj - gi)),
        .col_hit (w_col[PAIR_IDX]),
        .diag_hit(w_diag[PAIR_IDX])
      );
    end
  end

  always_comb begin
    w_err_code = ERR_NONE;
    if (!(&w_one_hot))  w_err_code = ERR_ONE_HOT;
    else if (|w_col)    w_err_code = ERR_COLUMN;
    else if (|w_diag)   w_err_code = ERR_DIAG;
  end

  assign in_ready       = (r_state == S_IDLE) || (r_state == S_CAPTURE);
  assign w_accept       = in_valid & in_ready;
  assign solution_valid = (r_state == S_REPORT) && (r_error_code == ERR_NONE);
  assign solution_error = (r_state == S_REPORT) && (r_error_code != ERR_NONE);
  assign error_code     = r_error_code;
  assign solution_count = r_count;
  assign truncated      = r_truncated;
  assign finished       = (r_state == S_FINISHED);
  assign read_data      = r_board[read_row];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_error_code <= ERR_NONE;
      r_count      <= '0;
      r_truncated  <= 1'b0;
      for (int k = 0; k < N_QUEENS; k++) begin
        r_slot[k]  <= '0;
        r_board[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          // A byte in the same cycle as search_done takes priority.
          if (w_accept) begin
            r_slot[0] <= in_row_data;
            r_idx     <= 3'd1;
            r_state   <= S_CAPTURE;
          end else if (search_done) begin
            r_state <= S_FINISHED;
          end
        end
        S_CAPTURE: begin
          if (w_accept) begin
            r_slot[r_idx] <= in_row_data;
            r_idx         <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_CHECK;
          end else if (search_done) begin
            r_truncated <= 1'b1;
            r_state     <= S_FINISHED;
          end
        end
        S_CHECK: begin
          r_error_code <= w_err_code;
          r_state      <= S_REPORT;
        end
        S_REPORT: begin
          if (r_error_code == ERR_NONE) begin
            if (r_count != '1) r_count <= r_count + COUNT_W'(1);
            for (int k = 0; k < N_QUEENS; k++) r_board[k] <= r_slot[k];
          end
          r_state <= S_IDLE;
        end
        S_FINISHED: r_state <= S_FINISHED;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_queen_solution_collector.sv
// Directed bench for queen_solution_collector: hand-built boards plus all 92
// solutions from an independent backtracking model.
module tb_queen_solution_collector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_row_data = '0;
  logic       in_ready;
  logic       search_done = 1'b0;
  logic       solution_valid;
  logic       solution_error;
  logic [1:0] error_code;
  logic [6:0] solution_count;
  logic       truncated;
  logic       finished;
  logic [2:0] read_row = '0;
  logic [7:0] read_data;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sols[$];

  // Boards packed row 7 .. row 0, so row i is bits [8*i +: 8].
  localparam logic [63:0] BRD_LEGAL = 64'h08_02_40_04_20_80_10_01;
  localparam logic [63:0] BRD_COL   = 64'h08_02_01_04_20_80_10_01;
  localparam logic [63:0] BRD_DIAG  = 64'h80_40_20_10_08_04_02_01;
  localparam logic [63:0] BRD_PRIO  = 64'h08_01_40_03_20_80_10_01;

  queen_solution_collector #(.COUNT_W(7)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_row_data   (in_row_data),
    .in_ready      (in_ready),
    .search_done   (search_done),
    .solution_valid(solution_valid),
    .solution_error(solution_error),
    .error_code    (error_code),
    .solution_count(solution_count),
    .truncated     (truncated),
    .finished      (finished),
    .read_row      (read_row),
    .read_data     (read_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    search_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives eight rows; a bubble follows row bubble_after. Returns in cycle N+1.
  task automatic send_board(input logic [63:0] brd, input int bubble_after);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_row_data = brd[8*i +: 8];
      if (i == bubble_after) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_report(input logic exp_ok, input logic [1:0] exp_code, input int exp_cnt);
    check_eq("check_ready", in_ready, 0);
    check_eq("check_pulse", solution_valid | solution_error, 0);
    @(negedge clk);
    check_eq("rep_valid", solution_valid, exp_ok);
    check_eq("rep_error", solution_error, !exp_ok);
    check_eq("rep_code", error_code, exp_code);
    check_eq("rep_ready", in_ready, 0);
    @(negedge clk);
    check_eq("post_ready", in_ready, 1);
    check_eq("post_pulse", solution_valid | solution_error, 0);
    check_eq("post_count", solution_count, exp_cnt);
  endtask

  task automatic build_model();
    int col[8];
    int r;
    bit ok;
    logic [7:0] one;
    logic [63:0] brd;
    one = 8'h01;
    r = 0;
    col[0] = -1;
    while (r >= 0) begin
      col[r]++;
      if (col[r] >= 8) begin
        r--;
      end else begin
        ok = 1'b1;
        for (int k = 0; k < r; k++)
          if (col[k] == col[r] || col[r] - col[k] == r - k || col[k] - col[r] == r - k)
            ok = 1'b0;
        if (ok) begin
          if (r == 7) begin
            for (int k = 0; k < 8; k++) brd[8*k +: 8] = one << col[k];
            sols.push_back(brd);
          end else begin
            r++;
            col[r] = -1;
          end
        end
      end
    end
  endtask

  initial begin
    build_model();
    check_eq("model_count", sols.size(), 92);
    check_eq("model_first", sols[0][31:0], BRD_LEGAL[31:0]);

    // Reset values
    do_reset();
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_valid", solution_valid, 0);
    check_eq("rst_error", solution_error, 0);
    check_eq("rst_code", error_code, 0);
    check_eq("rst_count", solution_count, 0);
    check_eq("rst_trunc", truncated, 0);
    check_eq("rst_fin", finished, 0);
    check_eq("rst_rdata", read_data, 0);

    // Legal board with a bubble after row 3
    send_board(BRD_LEGAL, 3);
    expect_report(1'b1, 2'b00, 1);
    read_row = 3'd2;
    #1 check_eq("legal_row2", read_data, 8'h80);
    read_row = 3'd7;
    #1 check_eq("legal_row7", read_data, 8'h08);

    // Column conflict: stored board must not change
    send_board(BRD_COL, 8);
    expect_report(1'b0, 2'b10, 1);
    read_row = 3'd5;
    #1 check_eq("col_keep_row5", read_data, 8'h40);
    read_row = 3'd2;
    #1 check_eq("col_keep_row2", read_data, 8'h80);

    send_board(BRD_DIAG, 8);
    expect_report(1'b0, 2'b11, 1);

    send_board(BRD_PRIO, 8);
    expect_report(1'b0, 2'b01, 1);

    // Reset in the middle of a capture
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_row_data = BRD_LEGAL[8*i +: 8];
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_ready", in_ready, 1);
    check_eq("mid_rst_count", solution_count, 0);
    check_eq("mid_rst_code", error_code, 0);
    check_eq("mid_rst_rdata", read_data, 0);
    check_eq("mid_rst_pulse", solution_valid | solution_error, 0);
    send_board(BRD_LEGAL, 8);
    expect_report(1'b1, 2'b00, 1);

    // search_done during a partial capture
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_row_data = BRD_LEGAL[8*i +: 8];
    end
    @(negedge clk);
    in_valid = 1'b0;
    search_done = 1'b1;
    @(negedge clk);
    check_eq("trunc_flag", truncated, 1);
    check_eq("trunc_fin", finished, 1);
    check_eq("trunc_ready", in_ready, 0);
    search_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_row_data = BRD_LEGAL[8*(c%8) +: 8];
      @(negedge clk);
      check_eq("trunc_no_pulse", solution_valid | solution_error, 0);
    end
    in_valid = 1'b0;
    check_eq("trunc_count", solution_count, 0);
    check_eq("trunc_fin_hold", finished, 1);

    // All 92 solutions back to back, then end of search
    do_reset();
    for (int s = 0; s < sols.size(); s++) begin
      send_board(sols[s], 8);
      expect_report(1'b1, 2'b00, s + 1);
    end
    search_done = 1'b1;
    @(negedge clk);
    search_done = 1'b0;
    check_eq("all_count", solution_count, 92);
    check_eq("all_fin", finished, 1);
    check_eq("all_trunc", truncated, 0);
    check_eq("all_ready", in_ready, 0);
    read_row = 3'd0;
    #1 check_eq("all_last_row0", read_data, sols[91][7:0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
